// File: rtl/sr_pkg.sv
// Shared types and the per-bit SR excitation rule for the SR bank driver.
package sr_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Returns {s, r} for one flop; never yields 2'b11.
  function automatic logic [1:0] excite_bit(input logic target, input logic q);
    return {target & ~q, ~target & q};
  endfunction

endpackage

// File: rtl/sr_excite.sv
// Combinational excitation generator: per-bit set/reset from target and current Q.
module sr_excite
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign {s_o[gi], r_o[gi]} = excite_bit(target_i[gi], q_i[gi]);
  end

  always_comb begin
    assert ((s_o & r_o) == '0) else $error("sr_excite: S and R both high");
  end

endmodule

// File: rtl/sr_bank_driver.sv
// Drives a bank of SR flops to a requested word: one-cycle S/R pulse, then polls Q
// feedback until it matches or a timeout expires, reporting done or err.
module sr_bank_driver
  import sr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] s_n, r_n;
  logic             match;

  sr_excite #(.WIDTH(WIDTH)) u_excite (
    .target_i (req_data),
    .q_i      (q_fb),
    .s_o      (s_n),
    .r_o      (r_n)
  );

  assign match = (q_fb == target_q);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    s_d        = '0;
    r_d        = '0;
    err_mask_d = err_mask_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d   = req_data;
          err_mask_d = '0;
          cnt_d      = '0;
          if (req_data == q_fb) begin
            // Already matching: skip the pulse and report immediately.
            state_d = ST_RESP;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            s_d     = s_n;
            r_d     = r_n;
          end
        end
      end
      ST_DRIVE: state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (match) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          err_mask_d = q_fb ^ target_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      s_q        <= '0;
      r_q        <= '0;
      err_mask_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      s_q        <= s_d;
      r_q        <= r_d;
      err_mask_q <= err_mask_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;

endmodule
